// File: rtl/axi_pkg.sv
// axi_pkg: AXI burst encodings, response codes and ROM FSM states
package axi_pkg;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_BURST} rd_state_t;
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wr_state_t;
endpackage

// File: rtl/axi_burst_rom_if.sv
// axi_burst_rom_if: AXI4 read/write channel bundle between a master and the ROM slave
interface axi_burst_rom_if #(
  parameter int ID_WIDTH = 1,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic [ID_WIDTH-1:0] awid;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/sync_rom.sv
// sync_rom: registered-output ROM; stand-in image holds each word's own index, empty image name reads zero
module sync_rom #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter string ROM_FILE = ""
) (
  input logic clk,
  input logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);
  localparam bit BLANK = ROM_FILE == "";
  always_ff @(posedge clk) data <= BLANK ? '0 : DATA_WIDTH'(addr);
endmodule

// File: rtl/axi_burst_rom.sv
// axi_burst_rom: AXI4 read-only burst slave over sync_rom; writes are drained and answered with SLVERR
module axi_burst_rom
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_BYTES = 1024,
  parameter int ID_WIDTH = 1,
  parameter string ROM_FILE = "boot.mem"
) (
  input logic clk,
  input logic rst,
  axi_burst_rom_if.slave axi
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int LB = $clog2(BPB);
  localparam int AW = $clog2(SIZE_BYTES / BPB);
  rd_state_t rs, rs_n;
  wr_state_t ws, ws_n;
  logic live, bad, err, accept, ar_hs, aw_hs, unused_bits;
  logic [ID_WIDTH-1:0] id, bid;
  logic [31:0] addr, rom_addr;
  logic [7:0] len, cnt;
  logic [1:0] burst;
  logic [DATA_WIDTH-1:0] q;
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l);
    logic [31:0] m;
    m = ((32'(l) + 32'd1) << LB) - 32'd1;
    return b == FIXED ? a : b == WRAP ? (a & ~m) | ((a + 32'(BPB)) & m) : a + 32'(BPB);
  endfunction
  assign ar_hs = axi.arvalid && axi.arready;
  assign aw_hs = axi.awvalid && axi.awready;
  assign accept = axi.rvalid && axi.rready;
  assign rom_addr = accept ? next_addr(addr, burst, len) : addr;
  assign err = bad || addr >= 32'(SIZE_BYTES);
  always_ff @(posedge clk) begin
    if (!rst) begin
      rs <= RD_IDLE;
      ws <= W_ADDR;
      live <= 1'b0;
      id <= '0;
      bid <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      burst <= '0;
      bad <= 1'b0;
    end else begin
      rs <= rs_n;
      ws <= ws_n;
      live <= 1'b1;
      if (ar_hs) begin
        id <= axi.arid;
        addr <= axi.araddr & ~32'(BPB - 1);
        len <= axi.arlen;
        cnt <= '0;
        burst <= axi.arburst;
        bad <= axi.arsize != 3'(LB) || axi.arburst == 2'd3 ||
               (axi.arburst == WRAP && !(axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
      end else if (accept) begin
        addr <= next_addr(addr, burst, len);
        cnt <= cnt + 8'd1;
      end
      if (aw_hs) bid <= axi.awid;
    end
  end
  always_comb begin
    rs_n = rs == RD_IDLE ? (ar_hs ? RD_FETCH : RD_IDLE) : rs == RD_FETCH ? RD_BURST :
           rs == RD_BURST && !(accept && axi.rlast) ? RD_BURST : RD_IDLE;
    ws_n = ws == W_ADDR ? (aw_hs ? W_DATA : W_ADDR) : ws == W_DATA ? (axi.wvalid && axi.wlast ? W_RESP : W_DATA) :
           ws == W_RESP && !axi.bready ? W_RESP : W_ADDR;
  end
  // live holds the ready outputs low for the first cycle out of reset
  assign axi.arready = live && rs == RD_IDLE;
  assign axi.rvalid = rs == RD_BURST;
  assign axi.rlast = axi.rvalid && cnt == len;
  assign axi.rresp = axi.rvalid && err ? RESP_SLVERR : RESP_OKAY;
  assign axi.rdata = axi.rvalid && !err ? q : '0;
  assign axi.rid = id;
  assign axi.awready = live && ws == W_ADDR;
  assign axi.wready = ws == W_DATA;
  assign axi.bvalid = ws == W_RESP;
  assign axi.bresp = axi.bvalid ? RESP_SLVERR : RESP_OKAY;
  assign axi.bid = bid;
  assign unused_bits = ^{axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.wdata, axi.wstrb, rom_addr};
  sync_rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DATA_WIDTH), .ROM_FILE(ROM_FILE)) u_rom (
    .clk(clk),
    .addr(rom_addr[AW+LB-1:LB]),
    .data(q)
  );
endmodule
